// File: rtl/mem_rr.sv
// Shared memory: one write port, NUMREAD read clients round-robin arbitrated onto one
// registered read port, plus a hardware clear sweep.
module mem_rr #(
    parameter int unsigned DATA    = 8,
    parameter int unsigned ADDR    = 16,
    parameter int unsigned NUMREAD = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [ADDR-1:0]                 w_addr,
    input  logic [DATA-1:0]                 w_data,
    input  logic                            clr_start,
    output logic                            busy,
    input  logic [NUMREAD-1:0]              rd_req,
    input  logic [NUMREAD-1:0][ADDR-1:0]    rd_addr,
    output logic [NUMREAD-1:0]              rd_ack,
    output logic [NUMREAD-1:0]              rd_valid,
    output logic [NUMREAD-1:0][DATA-1:0]    rd_data
);

    localparam int unsigned PtrW  = (NUMREAD > 1) ? $clog2(NUMREAD) : 1;
    localparam int unsigned Depth = 2 ** ADDR;

    typedef enum logic {StIdle, StClear} state_e;

    state_e                       state_q, state_d;
    logic [ADDR-1:0]              clr_cnt_q, clr_cnt_d;
    logic [PtrW-1:0]              ptr_q, ptr_d;
    logic [NUMREAD-1:0]           valid_q;
    logic [NUMREAD-1:0][DATA-1:0] rd_data_q;

    logic [DATA-1:0]    mem [Depth];
    logic               mem_we;
    logic [ADDR-1:0]    mem_waddr;
    logic [DATA-1:0]    mem_wdata;

    logic [NUMREAD-1:0] req_eff;
    logic               gnt_found;
    logic [PtrW-1:0]    gnt_idx;
    int unsigned        idx;
    logic [ADDR-1:0]    raddr;
    logic [DATA-1:0]    rdata_next;

    // FSM next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    assign busy = (state_q == StClear);

    // Write port is shared with the clear sweep; nothing is written while in reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_addr;
        mem_wdata = w_data;
        if (!rst) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end else begin
                mem_we = we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Round-robin search starting at ptr_q
    always_comb begin
        req_eff   = (state_q == StIdle && !rst) ? rd_req : '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUMREAD; k++) begin
            idx = (32'(ptr_q) + k) % NUMREAD;
            if (!gnt_found && req_eff[idx[PtrW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        rd_ack = '0;
        if (gnt_found) begin
            rd_ack[gnt_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == PtrW'(NUMREAD - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Write-first: a same-cycle write to the granted address is forwarded.
    assign raddr      = rd_addr[gnt_idx];
    assign rdata_next = (we && (w_addr == raddr)) ? w_data : mem[raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
            ptr_q     <= '0;
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            valid_q   <= rd_ack;
            if (gnt_found) begin
                rd_data_q[gnt_idx] <= rdata_next;
            end
        end
    end

    assign rd_valid = valid_q & {NUMREAD{~rst}};
    assign rd_data  = rd_data_q;

endmodule
